// File: rtl/alu_result_queue_if.sv
// rtl/alu_result_queue_if.sv - push/pop/status bundle between the ALU stage, the queue and its consumer
interface alu_result_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_result;
  logic                     in_carry;
  logic                     in_ovf;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_result;
  logic [3:0]               out_flags;
  logic [$clog2(DEPTH):0]   count;
  logic                     clr_sticky;
  logic                     sticky_c;
  logic                     sticky_v;

  modport slave (
    input  in_valid, in_result, in_carry, in_ovf, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_flags, count, sticky_c, sticky_v
  );

  modport master (
    output in_valid, in_result, in_carry, in_ovf, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_flags, count, sticky_c, sticky_v
  );
endinterface

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - first-word fall-through queue of ALU results with {C,V,N,Z} flags and sticky C/V
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             sticky_c_q;
  logic             sticky_v_q;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic [3:0]       new_flags;
  logic [WIDTH+3:0] head;

  // Handshake status depends only on registered occupancy, so there is no in->out combinational path
  assign in_ready  = (cnt < CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;
  assign new_flags = {bus.in_carry, bus.in_ovf, bus.in_result[WIDTH-1], (bus.in_result == '0)};
  assign head      = mem[rd_ptr];

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_valid ? head[WIDTH+3:4] : '0;
  assign bus.out_flags  = out_valid ? head[3:0] : 4'b0000;
  assign bus.count      = cnt;
  assign bus.sticky_c   = sticky_c_q;
  assign bus.sticky_v   = sticky_v_q;

  // Entry storage needs no reset: an empty queue masks the head to zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_result, new_flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A flag arriving with the clear pulse survives the clear
      sticky_c_q <= (sticky_c_q & ~bus.clr_sticky) | (push & bus.in_carry);
      sticky_v_q <= (sticky_v_q & ~bus.clr_sticky) | (push & bus.in_ovf);
    end
  end
endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - table, corner-case and randomized model checks for alu_result_queue
module tb_alu_result_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_result_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_result;
    logic        in_carry;
    logic        in_ovf;
    logic        out_ready;
    logic        clr;
    int          e_count;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [15:0] e_result;
    logic [3:0]  e_flags;
    logic        e_sc;
    logic        e_sv;
  } vec_t;

  vec_t vecs[15];

  logic [19:0] q[$];
  logic        m_sc;
  logic        m_sv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic c, input logic o,
                       input logic ordy, input logic clr);
    bus.in_valid   = v;
    bus.in_result  = r;
    bus.in_carry   = c;
    bus.in_ovf     = o;
    bus.out_ready  = ordy;
    bus.clr_sticky = clr;
  endtask

  task automatic check_model(input string tag);
    logic [19:0] hd;
    hd = (q.size() > 0) ? q[0] : 20'h0;
    chk({tag, ".count"},     32'(bus.count), 32'(q.size()));
    chk({tag, ".in_ready"},  32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".result"},    32'(bus.out_result), 32'(hd[19:4]));
    chk({tag, ".flags"},     32'(bus.out_flags), 32'(hd[3:0]));
    chk({tag, ".sticky_c"},  32'(bus.sticky_c), 32'(m_sc));
    chk({tag, ".sticky_v"},  32'(bus.sticky_v), 32'(m_sv));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    //        v  result    c  o  rdy clr  cnt ird ov  result    flags    sc sv
    vecs[0]  = '{1, 16'hFFFF, 1, 0, 0, 0,  1, 1, 1, 16'hFFFF, 4'b1010, 1, 0};
    vecs[1]  = '{1, 16'h0000, 0, 0, 1, 0,  1, 1, 1, 16'h0000, 4'b0001, 1, 0};
    vecs[2]  = '{0, 16'h0000, 0, 0, 1, 0,  0, 1, 0, 16'h0000, 4'b0000, 1, 0};
    vecs[3]  = '{0, 16'h0000, 0, 0, 1, 1,  0, 1, 0, 16'h0000, 4'b0000, 0, 0};
    vecs[4]  = '{1, 16'h0011, 0, 0, 0, 0,  1, 1, 1, 16'h0011, 4'b0000, 0, 0};
    vecs[5]  = '{1, 16'h8000, 0, 1, 0, 0,  2, 1, 1, 16'h0011, 4'b0000, 0, 1};
    vecs[6]  = '{1, 16'h1234, 0, 0, 0, 0,  3, 1, 1, 16'h0011, 4'b0000, 0, 1};
    vecs[7]  = '{1, 16'h7FFF, 1, 0, 0, 0,  4, 0, 1, 16'h0011, 4'b0000, 1, 1};
    vecs[8]  = '{1, 16'h5555, 0, 0, 0, 0,  4, 0, 1, 16'h0011, 4'b0000, 1, 1};
    vecs[9]  = '{1, 16'h5555, 0, 0, 1, 0,  3, 1, 1, 16'h8000, 4'b0110, 1, 1};
    vecs[10] = '{1, 16'h5555, 0, 0, 0, 0,  4, 0, 1, 16'h8000, 4'b0110, 1, 1};
    vecs[11] = '{0, 16'h0000, 0, 0, 1, 1,  3, 1, 1, 16'h1234, 4'b0000, 0, 0};
    vecs[12] = '{1, 16'h0001, 0, 1, 0, 1,  4, 0, 1, 16'h1234, 4'b0000, 0, 1};
    vecs[13] = '{0, 16'h0000, 0, 0, 1, 0,  3, 1, 1, 16'h7FFF, 4'b1000, 0, 1};
    vecs[14] = '{1, 16'h0002, 0, 0, 1, 0,  3, 1, 1, 16'h5555, 4'b0000, 0, 1};

    rst_n = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 0);
    #2;
    chk("reset.count",     32'(bus.count), 32'd0);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset.sticky_c",  32'(bus.sticky_c), 32'd0);
    chk("reset.sticky_v",  32'(bus.sticky_v), 32'd0);
    chk("reset.result",    32'(bus.out_result), 32'd0);
    chk("reset.flags",     32'(bus.out_flags), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_result, vecs[i].in_carry, vecs[i].in_ovf,
            vecs[i].out_ready, vecs[i].clr);
      @(posedge clk);
      #1;
      drive(0, 16'h0, 0, 0, 0, 0);
      chk($sformatf("vec%0d.count", i),     32'(bus.count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready), 32'(vecs[i].e_in_ready));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_out_valid));
      chk($sformatf("vec%0d.result", i),    32'(bus.out_result), 32'(vecs[i].e_result));
      chk($sformatf("vec%0d.flags", i),     32'(bus.out_flags), 32'(vecs[i].e_flags));
      chk($sformatf("vec%0d.sticky_c", i),  32'(bus.sticky_c), 32'(vecs[i].e_sc));
      chk($sformatf("vec%0d.sticky_v", i),  32'(bus.sticky_v), 32'(vecs[i].e_sv));
    end

    // Asynchronous reset between edges with three entries held
    #3 rst_n = 1'b0;
    #1;
    chk("async.count",     32'(bus.count), 32'd0);
    chk("async.out_valid", 32'(bus.out_valid), 32'd0);
    chk("async.in_ready",  32'(bus.in_ready), 32'd1);
    chk("async.sticky_v",  32'(bus.sticky_v), 32'd0);
    chk("async.result",    32'(bus.out_result), 32'd0);
    chk("async.flags",     32'(bus.out_flags), 32'd0);
    #2 rst_n = 1'b1;
    q.delete();
    m_sc = 1'b0;
    m_sv = 1'b0;
    @(posedge clk);
    #1;
    check_model("post_reset");

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        v, c, o, rdy, clr, do_push, do_pop;
      logic [15:0] r;
      v   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < ((cyc < 200) ? 40 : 70));
      clr = ($urandom_range(0, 99) < 10);
      c   = $urandom_range(0, 1);
      o   = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 5))
        0:       r = 16'h0000;
        1:       r = 16'hFFFF;
        2:       r = 16'h8000;
        default: r = 16'($urandom);
      endcase
      drive(v, r, c, o, rdy, clr);
      do_push = v && (q.size() < DEPTH);
      do_pop  = rdy && (q.size() > 0);
      @(posedge clk);
      #1;
      drive(0, 16'h0, 0, 0, 0, 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({r, c, o, r[15], (r == 16'h0000)});
      m_sc = (m_sc && !clr) || (do_push && c);
      m_sv = (m_sv && !clr) || (do_push && o);
      check_model($sformatf("rand%0d", cyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 16, result width matching the 16-bit ALU datapath.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, the ALU stage presents a result this cycle.
REQ-006 SHALL have port in_ready, output, 1, the queue accepts a result this cycle.
REQ-007 SHALL have port in_result, input, WIDTH, ALU result (adder sum or other op output).
REQ-008 SHALL have port in_carry, input, 1, adder carry-out for the result.
REQ-009 SHALL have port in_ovf, input, 1, signed-overflow flag for the result.
REQ-010 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer takes the head entry.
REQ-012 SHALL have port out_result, output, WIDTH, head entry result.
REQ-013 SHALL have port out_flags, output, 4, head entry flags {C,V,N,Z}, with bit 3 = C.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1, number of occupied entries.
REQ-015 SHALL have port clr_sticky, input, 1, a one-cycle pulse that clears the sticky flags.
REQ-016 SHALL have port sticky_c, output, 1, a carry was accepted since the last clear.
REQ-017 SHALL have port sticky_v, output, 1, an overflow was accepted since the last clear.

Function
REQ-018 SHALL implement a circular FIFO of DEPTH entries, each holding WIDTH result bits and 4 flag bits.
REQ-019 SHALL accept a push when in_valid and in_ready are both 1 at a clock edge.
REQ-020 SHALL perform a pop when out_valid and out_ready are both 1 at a clock edge.
REQ-021 SHALL drive in_ready = (count < DEPTH), combinationally from registered state only.
REQ-022 SHALL drive out_valid = (count != 0); out_result and out_flags SHALL come from the head entry (first-word fall-through).
REQ-023 SHALL raise out_valid on the clock edge after a push into an empty queue (latency 1 cycle); no combinational in->out path.
REQ-024 SHALL compute flags at push time: C=in_carry, V=in_ovf, N=in_result[WIDTH-1], Z=(in_result==0).
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL leave count unchanged on a simultaneous push and pop.
REQ-027 SHALL accept only the pop when a push is presented while full, because in_ready=0; count becomes DEPTH-1.
REQ-028 SHALL treat out_ready as don't-care while empty; count SHALL never underflow or exceed DEPTH.
REQ-029 SHALL keep out_result and out_flags stable while out_valid=1 and out_ready=0.
REQ-030 SHALL set sticky_c or sticky_v on an accepted push whose C or V is 1, and clear both on clr_sticky.
REQ-031 SHALL let the set win when clr_sticky coincides with an accepted push carrying a flag, so the event is not lost.
REQ-032 SHALL drive out_result and out_flags as 0 while empty.

Reset
REQ-033 SHALL, while rst_n=0 and independent of clk, force count=0, both pointers=0, out_valid=0, in_ready=1, sticky_c=0, sticky_v=0, out_result=0 and out_flags=0.
REQ-034 SHALL discard all stored entries on a reset asserted mid-operation, with no partial pop or push completing.
REQ-035 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-036 SHALL cover reset: rst_n=0 -> count=0, out_valid=0, in_ready=1, sticky_c=0, sticky_v=0.
REQ-037 SHALL cover ordering and flags: push 0xFFFF with in_carry=1, then push 0x0000, out_ready=1 -> first pop 0xFFFF with flags 1010, second pop 0x0000 with flags 0001, and sticky_c=1.
REQ-038 SHALL cover fill: 4 pushes with out_ready=0 -> count=4, in_ready=0; a 5th value held on in_result is accepted only after one pop.
REQ-039 SHALL cover full with simultaneous push and pop: count=4, in_valid=1, out_ready=1 -> head popped, push refused, count=3.
REQ-040 SHALL cover the clear/set collision: clr_sticky pulse in the same cycle as a push with in_ovf=1 -> sticky_v=1 afterwards.
REQ-041 SHALL cover async reset mid-operation: count=3, drop rst_n between clock edges -> count=0 and out_valid=0 immediately, before the next clk edge.
